// File: rtl/sr_drv_pkg.sv
// Shared opcodes and FSM state encoding for the SR latch drive sequencer.
package sr_drv_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_TOG = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT_PULSE,
        ST_INIT_GAP,
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } state_e;

endpackage

// File: rtl/sr_width_counter.sv
// Loadable down-counter timing pulse and gap phases; zero flag is registered.
module sr_width_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;

    // Load takes priority; otherwise count down and saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        zero_d = (cnt_d == '0);
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;

endmodule

// File: rtl/sr_drive_sequencer.sv
// Converts SET/CLEAR/TOGGLE/NOP commands into timed, non-overlapping s/r pulses
// for a gated SR latch, with a recovery gap and a shadow copy of the latch output.
module sr_drive_sequencer
    import sr_drv_pkg::*;
#(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       s,
    output logic       r,
    output logic       latch_en,
    output logic       busy,
    output logic       q_shadow,
    output logic [7:0] pulse_count
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_W == 0) ? 0 : (GAP_W - 1));

    state_e           state_q, state_d;
    logic             set_op_q, set_op_d;
    logic             q_shadow_q, q_shadow_d;
    logic [7:0]       pulse_count_q, pulse_count_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             latch_en_q, latch_en_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;
    logic             accept;

    sr_width_counter #(
        .CNT_W (CNT_W)
    ) u_width_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .en       (1'b1),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // Next-state, shadow/count update and registered-output decode.
    always_comb begin
        state_d       = state_q;
        set_op_d      = set_op_q;
        q_shadow_d    = q_shadow_q;
        pulse_count_d = pulse_count_q;
        cnt_load      = 1'b0;
        cnt_load_val  = PULSE_LOAD;
        accept        = cmd_valid & cmd_ready_q;

        case (state_q)
            ST_INIT_PULSE: begin
                // latch_en low here means this is the first cycle after reset.
                if (!latch_en_q) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = PULSE_LOAD;
                end else if (cnt_zero) begin
                    if (GAP_W == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_INIT_GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_LOAD;
                    end
                end
            end
            ST_INIT_GAP, ST_GAP: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept && (cmd_op != OP_NOP)) begin
                    set_op_d     = (cmd_op == OP_SET) || ((cmd_op == OP_TOG) && !q_shadow_q);
                    state_d      = ST_PULSE;
                    cnt_load     = 1'b1;
                    cnt_load_val = PULSE_LOAD;
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    q_shadow_d    = set_op_q;
                    pulse_count_d = pulse_count_q + 8'd1;
                    if (GAP_W == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_INIT_PULSE;
            end
        endcase

        latch_en_d  = (state_d == ST_INIT_PULSE) || (state_d == ST_PULSE);
        s_d         = (state_d == ST_PULSE) && set_op_d;
        r_d         = (state_d == ST_INIT_PULSE) || ((state_d == ST_PULSE) && !set_op_d);
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset overrides any in-flight pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_INIT_PULSE;
            set_op_q      <= 1'b0;
            q_shadow_q    <= 1'b0;
            pulse_count_q <= 8'd0;
            s_q           <= 1'b0;
            r_q           <= 1'b0;
            latch_en_q    <= 1'b0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            set_op_q      <= set_op_d;
            q_shadow_q    <= q_shadow_d;
            pulse_count_q <= pulse_count_d;
            s_q           <= s_d;
            r_q           <= r_d;
            latch_en_q    <= latch_en_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign s           = s_q;
    assign r           = r_q;
    assign latch_en    = latch_en_q;
    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign q_shadow    = q_shadow_q;
    assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Scoreboard bench for sr_drive_sequencer: the driver queues expected pulses,
// a monitor pops one per observed latch_en pulse and checks shape and effects.
module tb_sr_drive_sequencer;

    localparam int unsigned PULSE_W = 2;
    localparam int unsigned GAP_W   = 1;
    localparam int unsigned CNT_W   = 4;

    localparam logic [1:0] T_NOP = 2'b00;
    localparam logic [1:0] T_SET = 2'b01;
    localparam logic [1:0] T_CLR = 2'b10;
    localparam logic [1:0] T_TOG = 2'b11;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       s;
    logic       r;
    logic       latch_en;
    logic       busy;
    logic       q_shadow;
    logic [7:0] pulse_count;

    typedef struct {
        logic       s;
        logic       r;
        logic       q_before;
        logic       q_after;
        logic [7:0] cnt_before;
        logic [7:0] cnt_after;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       m_q     = 1'b0;
    logic [7:0] m_cnt   = 8'd0;

    sr_drive_sequencer #(
        .PULSE_W (PULSE_W),
        .GAP_W   (GAP_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_ready   (cmd_ready),
        .s           (s),
        .r           (r),
        .latch_en    (latch_en),
        .busy        (busy),
        .q_shadow    (q_shadow),
        .pulse_count (pulse_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the command effect; queues the pulse the monitor should see.
    task automatic push_cmd(input logic [1:0] op);
        exp_t e;
        logic set;
        if (op != T_NOP) begin
            set          = (op == T_SET) || ((op == T_TOG) && !m_q);
            e.s          = set;
            e.r          = !set;
            e.q_before   = m_q;
            e.cnt_before = m_cnt;
            m_q          = set;
            m_cnt        = m_cnt + 8'd1;
            e.q_after    = m_q;
            e.cnt_after  = m_cnt;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s"}, 32'(s), 0);
        chk({tag, "_r"}, 32'(r), 0);
        chk({tag, "_en"}, 32'(latch_en), 0);
        chk({tag, "_ready"}, 32'(cmd_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_q"}, 32'(q_shadow), 0);
        chk({tag, "_cnt"}, 32'(pulse_count), 0);
    endtask

    // Called at a negedge with reset high: release it and check INIT timing.
    task automatic release_reset();
        exp_t e;
        int   n;
        reset        = 1'b0;
        m_q          = 1'b0;
        m_cnt        = 8'd0;
        e.s          = 1'b0;
        e.r          = 1'b1;
        e.q_before   = 1'b0;
        e.q_after    = 1'b0;
        e.cnt_before = 8'd0;
        e.cnt_after  = 8'd0;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("init_ready_delay", 32'(n), 32'(PULSE_W + GAP_W));
        chk("init_idle_busy", 32'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_vals("rst");
        release_reset();
    endtask

    // Present one command, wait for accept, then measure cycles until ready.
    task automatic issue(input logic [1:0] op, input int exp_wait);
        int n;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = op;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("accept_timeout", 32'(n < 100), 1);
        push_cmd(op);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = T_NOP;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (exp_wait >= 0) chk("ready_gap", 32'(n), 32'(exp_wait));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("idle_timeout", 32'(n < 100), 1);
    endtask

    // Monitor: invariants every cycle and scoreboard compare per pulse.
    initial begin : monitor
        exp_t cur;
        int   len;
        logic in_pulse;
        in_pulse = 1'b0;
        len      = 0;
        forever begin
            @(posedge clock);
            #2;
            chk("inv_s_and_r", 32'(s & r), 0);
            chk("inv_gate", 32'(!latch_en && (s || r)), 0);
            if (reset) begin
                in_pulse = 1'b0;
            end else if (latch_en && !in_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'(latch_en), 0);
                end else begin
                    cur      = exp_q.pop_front();
                    in_pulse = 1'b1;
                    len      = 1;
                    chk("pulse_s", 32'(s), 32'(cur.s));
                    chk("pulse_r", 32'(r), 32'(cur.r));
                    chk("q_before", 32'(q_shadow), 32'(cur.q_before));
                    chk("cnt_before", 32'(pulse_count), 32'(cur.cnt_before));
                end
            end else if (latch_en && in_pulse) begin
                len++;
                chk("pulse_s_hold", 32'(s), 32'(cur.s));
                chk("pulse_r_hold", 32'(r), 32'(cur.r));
            end else if (!latch_en && in_pulse) begin
                in_pulse = 1'b0;
                chk("pulse_len", 32'(len), 32'(PULSE_W));
                chk("q_after", 32'(q_shadow), 32'(cur.q_after));
                chk("cnt_after", 32'(pulse_count), 32'(cur.cnt_after));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [1:0] ops [16];
        int         exp_acc [5];
        int         acc_cyc [$];

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = T_NOP;
        ops       = '{T_CLR, T_SET, T_TOG, T_SET, T_NOP, T_SET, T_CLR, T_CLR,
                      T_CLR, T_TOG, T_NOP, T_NOP, T_NOP, T_CLR, T_SET, T_SET};
        exp_acc   = '{0, 4, 5, 9, 13};

        // Reset held, then release and observe the INIT r-pulse.
        repeat (3) @(negedge clock);
        check_reset_vals("por");
        release_reset();
        chk("init_q", 32'(q_shadow), 0);
        chk("init_cnt", 32'(pulse_count), 0);

        // Single SET, then a NOP, then two TOGGLEs.
        issue(T_SET, 3);
        chk("set_q", 32'(q_shadow), 1);
        chk("set_cnt", 32'(pulse_count), 1);
        issue(T_NOP, 0);
        chk("nop_cnt", 32'(pulse_count), 1);
        issue(T_TOG, 3);
        chk("tog1_q", 32'(q_shadow), 0);
        issue(T_TOG, 3);
        chk("tog2_q", 32'(q_shadow), 1);
        chk("tog2_cnt", 32'(pulse_count), 3);

        // cmd_valid held high with a new opcode every cycle.
        wait_idle();
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            cmd_valid = 1'b1;
            cmd_op    = ops[i];
            if (cmd_ready) begin
                acc_cyc.push_back(i);
                push_cmd(ops[i]);
            end
        end
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_op    = T_NOP;
        chk("held_accepts", 32'(acc_cyc.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < acc_cyc.size()) chk("held_accept_cycle", 32'(acc_cyc[i]), 32'(exp_acc[i]));
        end
        wait_idle();
        chk("held_q", 32'(q_shadow), 0);
        chk("held_cnt", 32'(pulse_count), 7);

        // Reset asserted in the second cycle of a SET pulse.
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = T_SET;
        push_cmd(T_SET);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = T_NOP;
        chk("mid_pulse_s", 32'(s), 1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_vals("midrst");
        @(negedge clock);
        release_reset();

        // Wrap pulse_count with 257 alternating SET/CLEAR commands.
        for (int i = 0; i < 257; i++) begin
            issue(((i % 2) == 0) ? T_SET : T_CLR, 3);
            if (i == 255) chk("wrap_zero", 32'(pulse_count), 0);
        end
        chk("wrap_one", 32'(pulse_count), 1);
        chk("wrap_q", 32'(q_shadow), 1);

        repeat (4) @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_drive_sequencer.md
# sr_drive_sequencer

Upstream driver for the gated SR latch. It accepts SET/CLEAR/TOGGLE/NOP commands over a valid/ready handshake and converts each one into a timed pulse on the latch's `s`/`r` and gate-enable inputs. It guarantees that `s` and `r` are never both high, and inserts a configurable recovery gap between pulses. After reset it forces the latch into a known state (q=0) and keeps a shadow copy of the expected latch output.

## Interface
- `PULSE_W`, default 2: cycles `s`/`r` and `latch_en` stay high per pulse; legal 1..2^CNT_W-1.
- `GAP_W`, default 1: cycles of s=r=latch_en=0 after each pulse; legal 0..2^CNT_W-1.
- `CNT_W`, default 4: width of the internal cycle counter.
- `clock  in  1`: the single clock; all state updates on its rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `cmd_valid  in  1`: command present.
- `cmd_op  in  2`: 00 NOP, 01 SET, 10 CLEAR, 11 TOGGLE.
- `cmd_ready  out  1`: block can accept a command this cycle.
- `s  out  1`: latch set input.
- `r  out  1`: latch reset input.
- `latch_en  out  1`: latch gate enable; high only while a pulse is driven.
- `busy  out  1`: high in every state except IDLE.
- `q_shadow  out  1`: expected latch q.
- `pulse_count  out  8`: number of SET/CLEAR pulses issued since reset; wraps.

## Operation
- States: INIT_PULSE, INIT_GAP, IDLE, PULSE, GAP.
- Reset (held high): state=INIT_PULSE, cnt=0, s=r=latch_en=0, cmd_ready=0, busy=1, q_shadow=0, pulse_count=0.
- INIT_PULSE: r=1, latch_en=1 for PULSE_W cycles. Then INIT_GAP, or IDLE if GAP_W=0. Not counted in pulse_count.
- INIT_GAP and GAP: s=r=latch_en=0 for GAP_W cycles, then IDLE.
- IDLE: cmd_ready=1, busy=0, outputs low.
- Accept happens when `cmd_valid & cmd_ready` is high at an edge.
  - NOP: consumed, stays in IDLE, no pulse, no count.
  - SET/CLEAR: go to PULSE with s=1 (SET) or r=1 (CLEAR).
  - TOGGLE resolves from q_shadow at the accept edge: CLEAR if q_shadow=1, SET if q_shadow=0.
- A redundant command (SET while q_shadow=1) still issues a pulse.
- PULSE: the chosen line plus latch_en are high for PULSE_W cycles.
  - On the exit edge: q_shadow is set to 1 for SET and 0 for CLEAR, and pulse_count increments modulo 256 (255 to 0).
  - Exit goes to GAP, or IDLE if GAP_W=0.
- The command opcode is latched at accept; cmd_valid and cmd_op while busy are ignored.
- Invariant at every cycle: !(s & r); latch_en==0 implies s==r==0.
- Reset mid-operation takes priority over everything. The in-flight pulse is aborted, reset values apply from the next edge, and the INIT sequence reruns after release.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Accept at edge k: s/r/latch_en are high after edges k..k+PULSE_W-1, low after edge k+PULSE_W.
- cmd_ready returns after edge k+PULSE_W+GAP_W. Minimum command spacing is PULSE_W+GAP_W+1 cycles.
- q_shadow and pulse_count change at edge k+PULSE_W.
- Reset release at edge 0 (reset sampled low): INIT r-pulse is visible after edges 0..PULSE_W-1. cmd_ready=1 first after edge PULSE_W+GAP_W.
- NOP accept: cmd_ready stays 1, so the next command can be accepted the following cycle.

## Structure
- Shared package `sr_drv_pkg` holds:
  - the opcode constants (OP_NOP, OP_SET, OP_CLR, OP_TOG);
  - the state enum typedef.
- Sub-module `sr_width_counter`: loadable down-counter (CNT_W bits). It has load value, load, and enable inputs and a `zero` flag. One instance is shared by the PULSE and GAP phases.
- The top level holds the FSM, the shadow register and pulse_count.

## Test plan
- Release reset with PULSE_W=2, GAP_W=1:
  - expect r=1, latch_en=1 for 2 cycles, then 1 idle cycle;
  - cmd_ready=1 on the 4th cycle;
  - q_shadow=0, pulse_count=0.
- SET accepted in IDLE: expect s=1, latch_en=1 for 2 cycles, r=0 throughout; then q_shadow=1, pulse_count=1, ready again 3 cycles after accept.
- TOGGLE, TOGGLE from q_shadow=1: expect an r pulse then an s pulse; q_shadow 0 then 1; pulse_count +2.
- cmd_valid held high with changing cmd_op:
  - accepts occur exactly every 4 cycles;
  - ops presented while busy are ignored;
  - NOP produces no pulse and is followed by an accept on the next cycle.
- Assert reset for 1 cycle during the second PULSE cycle: expect s=r=latch_en=0 next edge, q_shadow=0, then the INIT r-pulse reruns.
- Issue 257 SET/CLEAR commands: pulse_count reads 1 after wrap. Assert !(s&r) and latch_en-gating every cycle.
